blctrl_scheduler: RTL and testbench
===================================

Name: blctrl_scheduler

Overview:
Sequences BL-Ctrl motor speed writes onto a single shared I2C master byte engine. It latches the 8 decoded DShot throttle bytes, keeps a pending flag per motor and services pending motors in round-robin order. A refresh timer keeps ESCs alive, and a per-motor failsafe forces throttle to 0 when a DShot channel goes silent. It sits between the eight speedhandler instances and the I2C master.

Parameters:
NUM_MOTORS, 8, number of channels (logic is written for 8)
BASE_ADDR, 7'h29, 7-bit I2C address of motor 1; motor n uses BASE_ADDR+n-1
REFRESH_CYCLES, 16000, global refresh period in clk cycles (1 ms at 16 MHz)
FAILSAFE_CYCLES, 1600000, cycles without speed_valid before a channel enters failsafe (100 ms)
TXN_TIMEOUT, 4096, maximum cycles from ack to done before a transaction is aborted

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous reset, active-high
master_enable  in  1  0 = issue no new transactions
motor_enable  in  8  bit i enables motor i+1
speed_flat  in  64  motor1 at [63:56] through motor8 at [7:0]
speed_valid  in  8  1-cycle strobe: new speed byte for motor i+1
i2c_req  out  1  request to the I2C engine; held until i2c_ack
i2c_addr  out  7  target address; stable while i2c_req=1
i2c_data  out  8  throttle byte; stable while i2c_req=1
i2c_ack  in  1  engine accepted the request (1 cycle)
i2c_done  in  1  transaction finished (1 cycle)
i2c_nack  in  1  qualifies i2c_done: slave NACKed
nack_clear  in  1  pulse: clears nack_sticky
failsafe  out  8  motor i+1 is in failsafe
nack_sticky  out  8  motor i+1 has seen a NACK or timeout since the last clear
busy  out  1  FSM is not in IDLE
cur_motor  out  3  index of the motor being serviced

Behaviour:
- Reset: all outputs 0. Shadow speeds, pending flags, rr_ptr, refresh timer, failsafe counters and the txn timer all go to 0. FSM goes to IDLE. Reset mid-transaction drops i2c_req at once; the engine is expected to share rst.
- Capture: speed_valid[i] at cycle t:
  - shadow[i] <= speed byte.
  - pending[i] <= 1.
  - fs_cnt[i] <= 0.
  - failsafe[i] <= 0.
  - All four take effect at t+1.
- Failsafe: fs_cnt[i] increments every cycle and saturates. When it reaches FAILSAFE_CYCLES-1 without a valid, at the next edge: failsafe[i]=1, shadow[i]=0, pending[i]=1. The set fires once, on entry only. If valid arrives on the same cycle, valid wins.
- Refresh: the timer counts 0..REFRESH_CYCLES-1 and wraps. On wrap, pending[i] is set for every enabled motor.
- Pending set/clear collision (snapshot clear and valid/refresh on the same cycle): set wins.
- FSM states IDLE, REQ, WAIT.
  - IDLE: if master_enable=1 and (pending & motor_enable) != 0, select the first set bit at or after rr_ptr, wrapping from 7 to 0. In the same cycle:
    - latch idx and cur_motor;
    - snapshot i2c_data = shadow[idx] and i2c_addr = BASE_ADDR+idx;
    - clear pending[idx];
    - go to REQ.
  - REQ: i2c_req=1; addr and data are held. On i2c_ack: drop i2c_req next cycle, clear the txn timer, go to WAIT.
  - WAIT:
    - On i2c_done with i2c_nack=1: set nack_sticky[idx]. Pending is not re-armed; the next refresh retries.
    - On i2c_done with i2c_nack=0: no flag change.
    - In both done cases: rr_ptr=idx+1 mod 8, go to IDLE.
    - If the txn timer reaches TXN_TIMEOUT-1 with no done: set nack_sticky[idx], advance rr_ptr the same way, go to IDLE.
- Latency: a valid at cycle t on an idle scheduler gives i2c_req=1 at t+2. Back-to-back service: IDLE lasts 1 cycle between transactions.
- master_enable=0: no new selection. A transaction in flight completes normally. Pending flags are retained.
- motor_enable[i]=0: the motor is skipped; its pending flag is retained; failsafe still runs.
- nack_clear together with a new NACK on the same cycle: the set wins for that bit.
- busy = (state != IDLE).

Test Plan:
- Single update: speed_valid[0] with speed_flat[63:56]=8'h80 → i2c_req=1 two cycles later with addr=7'h29, data=8'h80; ack, then done → pending[0] cleared, busy=0.
- Round robin: valids for motors 3, 1 and 8 in the same cycle with rr_ptr=0 → service order is addr 7'h29, 7'h2B, 7'h30; rr_ptr=0 after the third.
- Data during transaction: a new valid for motor 1 (8'h10 → 8'h20) while in WAIT → the current txn sends 8'h10, then a second txn to 7'h29 sends 8'h20.
- Failsafe: motor 2 silent for FAILSAFE_CYCLES (use a reduced parameter) → failsafe[1]=1 and a write of 8'h00 to 7'h2A. A following valid of 8'h40 → failsafe[1]=0 and a write of 8'h40.
- NACK and timeout: done with nack=1 on motor 5 → nack_sticky=8'h10. Withholding done for TXN_TIMEOUT on motor 6 → nack_sticky=8'h30, FSM back in IDLE. nack_clear → 8'h00.
- Enables, refresh and reset: master_enable=0 with pending set → no req; at re-enable → req. Refresh wrap with motor_enable=8'h0F → exactly 4 writes, to 7'h29..7'h2C. rst asserted in REQ → i2c_req=0 and all outputs 0 on the next cycle.

Source files
------------

// File: rtl/blctrl_scheduler_if.sv
// Handshake between the BL-Ctrl scheduler and the shared I2C master byte engine.
// The scheduler holds req/addr/data until ack, then waits for a done pulse qualified by nack.
interface blctrl_scheduler_if;
  logic       i2c_req;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_data;
  logic       i2c_ack;
  logic       i2c_done;
  logic       i2c_nack;

  modport master (
    output i2c_req, i2c_addr, i2c_data,
    input  i2c_ack, i2c_done, i2c_nack
  );

  modport slave (
    input  i2c_req, i2c_addr, i2c_data,
    output i2c_ack, i2c_done, i2c_nack
  );
endinterface

// File: rtl/blctrl_scheduler.sv
// Round-robin scheduler that turns latched DShot throttle bytes into BL-Ctrl I2C speed writes,
// with a global keep-alive refresh and a per-channel failsafe that forces throttle to zero.
module blctrl_scheduler #(
  parameter int         NUM_MOTORS      = 8,
  parameter logic [6:0] BASE_ADDR       = 7'h29,
  parameter int         REFRESH_CYCLES  = 16000,
  parameter int         FAILSAFE_CYCLES = 1600000,
  parameter int         TXN_TIMEOUT     = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    master_enable,
  input  logic [NUM_MOTORS-1:0]   motor_enable,
  input  logic [8*NUM_MOTORS-1:0] speed_flat,
  input  logic [NUM_MOTORS-1:0]   speed_valid,
  blctrl_scheduler_if.master      bus,
  input  logic                    nack_clear,
  output logic [NUM_MOTORS-1:0]   failsafe,
  output logic [NUM_MOTORS-1:0]   nack_sticky,
  output logic                    busy,
  output logic [2:0]              cur_motor
);

  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int FW = $clog2(FAILSAFE_CYCLES);
  localparam int TW = $clog2(TXN_TIMEOUT);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [FW-1:0] FS_LAST  = FW'(FAILSAFE_CYCLES - 1);
  localparam logic [TW-1:0] TXN_LAST = TW'(TXN_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                  state;
  logic [7:0]              shadow [NUM_MOTORS];
  logic [FW-1:0]           fs_cnt [NUM_MOTORS];
  logic [NUM_MOTORS-1:0]   pending;
  logic [NUM_MOTORS-1:0]   pending_nxt;
  logic [NUM_MOTORS-1:0]   fs_trip;
  logic [NUM_MOTORS-1:0]   cand;
  logic [NUM_MOTORS-1:0]   nack_set;
  logic [RW-1:0]           ref_cnt;
  logic [TW-1:0]           txn_cnt;
  logic [2:0]              rr_ptr;
  logic [2:0]              pick;
  logic                    ref_wrap;
  logic                    sel_go;

  // First requesting motor at or after ptr, wrapping 7 -> 0.
  function automatic logic [2:0] rr_pick(input logic [NUM_MOTORS-1:0] req, input logic [2:0] ptr);
    logic [2:0] p;
    logic [2:0] i;
    logic       found;
    p     = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_MOTORS; k++) begin
      i = ptr + 3'(k);
      if (!found && req[i]) begin
        p     = i;
        found = 1'b1;
      end
    end
    return p;
  endfunction

  always_comb begin
    ref_wrap = (ref_cnt == REF_LAST);
    cand     = pending & motor_enable;
    pick     = rr_pick(cand, rr_ptr);
    sel_go   = (state == IDLE) && master_enable && (cand != '0);
    for (int i = 0; i < NUM_MOTORS; i++) begin
      fs_trip[i] = (fs_cnt[i] == FS_LAST) && !failsafe[i] && !speed_valid[i];
    end
    // Sets are applied after the snapshot clear so a same-cycle set wins.
    pending_nxt = pending;
    if (sel_go) pending_nxt[pick] = 1'b0;
    pending_nxt = pending_nxt | speed_valid | fs_trip | (ref_wrap ? motor_enable : '0);
    nack_set = '0;
    if (state == WAIT && ((bus.i2c_done && bus.i2c_nack) || (!bus.i2c_done && txn_cnt == TXN_LAST)))
      nack_set[cur_motor] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      failsafe <= '0;
      ref_cnt  <= '0;
      for (int i = 0; i < NUM_MOTORS; i++) begin
        shadow[i] <= '0;
        fs_cnt[i] <= '0;
      end
    end else begin
      pending <= pending_nxt;
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      for (int i = 0; i < NUM_MOTORS; i++) begin
        if (speed_valid[i]) begin
          shadow[i]   <= speed_flat[8*(NUM_MOTORS-1-i) +: 8];
          fs_cnt[i]   <= '0;
          failsafe[i] <= 1'b0;
        end else begin
          if (fs_cnt[i] != FS_LAST) fs_cnt[i] <= fs_cnt[i] + 1'b1;
          if (fs_trip[i]) begin
            failsafe[i] <= 1'b1;
            shadow[i]   <= '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bus.i2c_req  <= 1'b0;
      bus.i2c_addr <= '0;
      bus.i2c_data <= '0;
      cur_motor    <= '0;
      rr_ptr       <= '0;
      txn_cnt      <= '0;
      nack_sticky  <= '0;
    end else begin
      nack_sticky <= (nack_clear ? '0 : nack_sticky) | nack_set;
      case (state)
        IDLE: begin
          if (sel_go) begin
            cur_motor    <= pick;
            bus.i2c_addr <= BASE_ADDR + {4'd0, pick};
            bus.i2c_data <= shadow[pick];
            bus.i2c_req  <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (bus.i2c_ack) begin
            bus.i2c_req <= 1'b0;
            txn_cnt     <= '0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // A NACKed or timed-out motor is not re-armed; the next refresh retries it.
          if (bus.i2c_done || txn_cnt == TXN_LAST) begin
            rr_ptr <= cur_motor + 3'd1;
            state  <= IDLE;
          end else begin
            txn_cnt <= txn_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_blctrl_scheduler.sv
// Directed bench for blctrl_scheduler with reduced timer parameters and a scripted I2C engine.
module tb_blctrl_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        master_enable;
  logic [7:0]  motor_enable;
  logic [63:0] speed_flat;
  logic [7:0]  speed_valid;
  logic        nack_clear;
  logic [7:0]  failsafe;
  logic [7:0]  nack_sticky;
  logic        busy;
  logic [2:0]  cur_motor;
  int          nvec = 0;
  int          nfail = 0;

  blctrl_scheduler_if bus();

  blctrl_scheduler #(
    .NUM_MOTORS(8), .BASE_ADDR(7'h29), .REFRESH_CYCLES(1000),
    .FAILSAFE_CYCLES(600), .TXN_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .master_enable(master_enable), .motor_enable(motor_enable),
    .speed_flat(speed_flat), .speed_valid(speed_valid), .bus(bus.master),
    .nack_clear(nack_clear), .failsafe(failsafe), .nack_sticky(nack_sticky),
    .busy(busy), .cur_motor(cur_motor)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_valid(input logic [7:0] mask, input logic [63:0] flat);
    @(negedge clk);
    speed_flat  = flat;
    speed_valid = mask;
    @(negedge clk);
    speed_valid = 8'h00;
  endtask

  task automatic wait_req(input int limit);
    int n;
    n = 0;
    while (bus.i2c_req !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 64'(bus.i2c_req), 64'd1);
  endtask

  task automatic take(input string tag, input logic [6:0] addr, input logic [7:0] data, input int limit);
    wait_req(limit);
    chk({tag, "_addr"}, 64'(bus.i2c_addr), 64'(addr));
    chk({tag, "_data"}, 64'(bus.i2c_data), 64'(data));
    chk({tag, "_cur"}, 64'(cur_motor), 64'(addr - 7'h29));
    bus.i2c_ack = 1'b1;
    @(negedge clk);
    bus.i2c_ack = 1'b0;
    chk({tag, "_req_drop"}, 64'(bus.i2c_req), 64'd0);
    chk({tag, "_busy_wait"}, 64'(busy), 64'd1);
  endtask

  task automatic finish(input string tag, input logic nack, input logic clr);
    repeat (2) @(negedge clk);
    bus.i2c_done = 1'b1;
    bus.i2c_nack = nack;
    nack_clear   = clr;
    @(negedge clk);
    bus.i2c_done = 1'b0;
    bus.i2c_nack = 1'b0;
    nack_clear   = 1'b0;
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; master_enable = 1'b1; motor_enable = 8'hFF; speed_flat = '0;
    speed_valid = '0; nack_clear = 1'b0;
    bus.i2c_ack = 1'b0; bus.i2c_done = 1'b0; bus.i2c_nack = 1'b0;

    // Reset state
    do_reset();
    chk("rst_req", 64'(bus.i2c_req), 64'd0);
    chk("rst_addr", 64'(bus.i2c_addr), 64'd0);
    chk("rst_data", 64'(bus.i2c_data), 64'd0);
    chk("rst_flags", {failsafe, nack_sticky, 7'd0, busy, 5'd0, cur_motor}, 64'd0);

    // Single update with two-cycle latency
    pulse_valid(8'h01, 64'h80_00_00_00_00_00_00_00);
    chk("lat_t1", 64'(bus.i2c_req), 64'd0);
    @(negedge clk);
    chk("lat_t2", 64'(bus.i2c_req), 64'd1);
    take("single", 7'h29, 8'h80, 5);
    finish("single", 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    chk("single_quiet", 64'(bus.i2c_req), 64'd0);

    // Round robin: motors 1, 3, 8 together, then 1 and 8 again from rr_ptr 0
    do_reset();
    pulse_valid(8'h85, 64'h11_00_33_00_00_00_00_88);
    take("rr1", 7'h29, 8'h11, 10); finish("rr1", 1'b0, 1'b0);
    take("rr2", 7'h2B, 8'h33, 10); finish("rr2", 1'b0, 1'b0);
    take("rr3", 7'h30, 8'h88, 10); finish("rr3", 1'b0, 1'b0);
    pulse_valid(8'h81, 64'h01_00_00_00_00_00_00_08);
    take("rr4", 7'h29, 8'h01, 10); finish("rr4", 1'b0, 1'b0);
    take("rr5", 7'h30, 8'h08, 10); finish("rr5", 1'b0, 1'b0);

    // New data for motor 1 arriving while its write is in flight
    do_reset();
    pulse_valid(8'h01, 64'h10_00_00_00_00_00_00_00);
    take("inflt1", 7'h29, 8'h10, 10);
    pulse_valid(8'h01, 64'h20_00_00_00_00_00_00_00);
    finish("inflt1", 1'b0, 1'b0);
    take("inflt2", 7'h29, 8'h20, 10); finish("inflt2", 1'b0, 1'b0);

    // Failsafe entry on silent channels, then recovery of motor 2
    do_reset();
    motor_enable = 8'h02;
    n = 0;
    while (failsafe[1] !== 1'b1 && n < 800) begin
      @(negedge clk);
      n++;
    end
    chk("fs_enter", 64'(failsafe), 64'hFF);
    take("fs_zero", 7'h2A, 8'h00, 10); finish("fs_zero", 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("fs_once", 64'(bus.i2c_req), 64'd0);
    pulse_valid(8'h02, 64'h00_40_00_00_00_00_00_00);
    chk("fs_exit", 64'(failsafe), 64'hFD);
    take("fs_resume", 7'h2A, 8'h40, 10); finish("fs_resume", 1'b0, 1'b0);

    // NACK on motor 5, timeout on motor 6, clear/NACK collision, then clear
    do_reset();
    motor_enable = 8'hFF;
    pulse_valid(8'h10, 64'h00_00_00_00_55_00_00_00);
    take("nack5", 7'h2D, 8'h55, 10); finish("nack5", 1'b1, 1'b0);
    chk("nack_sticky5", 64'(nack_sticky), 64'h10);
    pulse_valid(8'h20, 64'h00_00_00_00_00_66_00_00);
    take("tmo6", 7'h2E, 8'h66, 10);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_idle", 64'(busy), 64'd0);
    chk("tmo_sticky", 64'(nack_sticky), 64'h30);
    pulse_valid(8'h10, 64'h00_00_00_00_55_00_00_00);
    take("coll5", 7'h2D, 8'h55, 10); finish("coll5", 1'b1, 1'b1);
    chk("coll_sticky", 64'(nack_sticky), 64'h10);
    @(negedge clk);
    nack_clear = 1'b1;
    @(negedge clk);
    nack_clear = 1'b0;
    chk("clr_sticky", 64'(nack_sticky), 64'h00);

    // master_enable gating with a retained pending flag
    do_reset();
    master_enable = 1'b0;
    pulse_valid(8'h01, 64'h77_00_00_00_00_00_00_00);
    repeat (20) @(negedge clk);
    chk("men_off_req", 64'(bus.i2c_req), 64'd0);
    chk("men_off_busy", 64'(busy), 64'd0);
    master_enable = 1'b1;
    @(negedge clk);
    chk("men_on_req", 64'(bus.i2c_req), 64'd1);
    take("men_on", 7'h29, 8'h77, 5); finish("men_on", 1'b0, 1'b0);

    // Refresh with motors 1-4 enabled: failsafe round first, then the timer wrap
    do_reset();
    motor_enable = 8'h0F;
    take("fsr1", 7'h29, 8'h00, 1200); finish("fsr1", 1'b0, 1'b0);
    take("fsr2", 7'h2A, 8'h00, 10);   finish("fsr2", 1'b0, 1'b0);
    take("fsr3", 7'h2B, 8'h00, 10);   finish("fsr3", 1'b0, 1'b0);
    take("fsr4", 7'h2C, 8'h00, 10);   finish("fsr4", 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    chk("fsr_quiet", 64'(bus.i2c_req), 64'd0);
    take("ref1", 7'h29, 8'h00, 1200); finish("ref1", 1'b0, 1'b0);
    take("ref2", 7'h2A, 8'h00, 10);   finish("ref2", 1'b0, 1'b0);
    take("ref3", 7'h2B, 8'h00, 10);   finish("ref3", 1'b0, 1'b0);
    take("ref4", 7'h2C, 8'h00, 10);   finish("ref4", 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    chk("ref_exact4", 64'(bus.i2c_req), 64'd0);

    // Reset asserted while a request is outstanding
    pulse_valid(8'h04, 64'h00_00_3C_00_00_00_00_00);
    take("pre_rst", 7'h2B, 8'h3C, 10); finish("pre_rst", 1'b1, 1'b0);
    chk("pre_rst_sticky", 64'(nack_sticky), 64'h04);
    pulse_valid(8'h04, 64'h00_00_5A_00_00_00_00_00);
    wait_req(10);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", 64'(bus.i2c_req), 64'd0);
    chk("mid_rst_addr", 64'(bus.i2c_addr), 64'd0);
    chk("mid_rst_data", 64'(bus.i2c_data), 64'd0);
    chk("mid_rst_flags", {failsafe, nack_sticky, 7'd0, busy, 5'd0, cur_motor}, 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_quiet", 64'(bus.i2c_req), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
